pc_unit: RTL

- Parametrised program-counter unit; successor to the fixed 32-bit +1 counter.
- Per clock it selects the next PC from: sequential increment by STEP, branch/call target, return-address-stack (RAS) pop, or trap vector.
- Sits at the head of the fetch stage; drives the instruction-memory address.
- Supports stall, call/return tracking and wrap-around.

---
 rtl/pc_pkg.sv | 28 ++
 rtl/pc_unit_if.sv | 40 ++++
 rtl/pc_ras.sv | 55 +++++
 rtl/pc_unit.sv | 135 +++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types, default constants and helpers for the program-counter unit.
// Optional build macro used by this slice: PC_ALIGN_CHECK_EN.
package pc_pkg;

  typedef enum logic [1:0] {
    PC_SEL_INC,
    PC_SEL_BR,
    PC_SEL_RET,
    PC_SEL_TRAP
  } pc_sel_e;

  localparam int unsigned DEF_WIDTH     = 32;
  localparam int unsigned DEF_STEP      = 4;
  localparam int unsigned DEF_RAS_DEPTH = 4;
  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0100;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Control/status bundle between the fetch controller and the PC unit.
// PC_ALIGN_CHECK_EN adds the misalign status signal.
interface pc_unit_if
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);
  logic             enable;
  logic             branch_taken;
  logic             call;
  logic             ret;
  logic             trap;
  logic [WIDTH-1:0] branch_target;
  logic [WIDTH-1:0] pc;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_overflow;
  logic             ras_underflow;
`ifdef PC_ALIGN_CHECK_EN
  logic             misalign;

  modport master (
    output enable, branch_taken, call, ret, trap, branch_target,
    input  pc, ras_empty, ras_full, ras_overflow, ras_underflow, misalign
  );
  modport slave (
    input  enable, branch_taken, call, ret, trap, branch_target,
    output pc, ras_empty, ras_full, ras_overflow, ras_underflow, misalign
  );
`else
  modport master (
    output enable, branch_taken, call, ret, trap, branch_target,
    input  pc, ras_empty, ras_full, ras_overflow, ras_underflow
  );
  modport slave (
    input  enable, branch_taken, call, ret, trap, branch_target,
    output pc, ras_empty, ras_full, ras_overflow, ras_underflow
  );
`endif
endinterface

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer addressed by a top pointer plus an
// entry count. A push when full overwrites the oldest entry and sets the
// sticky overflow flag; a pop when empty is ignored.
module pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned RAS_DEPTH = DEF_RAS_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full,
  output logic             overflow
);
  localparam int unsigned      PTR_W   = clog2(RAS_DEPTH);
  localparam int unsigned      CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_inc;
  logic [CNT_W-1:0] count;

  assign ptr_inc = ptr + PTR_W'(1);
  assign top     = mem[ptr];
  assign empty   = (count == '0);
  assign full    = (count == CNT_MAX);

  // Pointer, occupancy and sticky overflow tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr      <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (push) begin
      ptr <= ptr_inc;
      if (full) overflow <= 1'b1;
      else      count    <= count + CNT_W'(1);
    end else if (pop && !empty) begin
      ptr   <= ptr - PTR_W'(1);
      count <= count - CNT_W'(1);
    end
  end

  // Entry storage; contents are unreachable after reset since count is 0.
  always_ff @(posedge clk) begin
    if (push) mem[ptr_inc] <= push_data;
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit at the head of fetch: selects the next PC from
// increment, branch/call target, RAS pop or trap vector each cycle.
// Build macro PC_ALIGN_CHECK_EN: misaligned branch/call targets trap and
// pulse misalign instead of being silently masked.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH     = DEF_WIDTH,
  parameter int unsigned      STEP      = DEF_STEP,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEF_RESET_VEC),
  parameter logic [WIDTH-1:0] TRAP_VEC  = WIDTH'(DEF_TRAP_VEC),
  parameter int unsigned      RAS_DEPTH = DEF_RAS_DEPTH
) (
  input logic       clk,
  input logic       rst,
  pc_unit_if.slave  bus
);
  localparam logic [WIDTH-1:0] STEP_V   = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'((32'd1 << clog2(STEP)) - 32'd1);

  pc_sel_e          sel;
  logic             push;
  logic             pop;
  logic             underflow_next;
  logic             misalign_next;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] ret_addr;
  logic [WIDTH-1:0] ras_top;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_overflow;
  logic             underflow_q;
  logic             misalign_q;

  assign pc_inc = pc_q + STEP_V;
  assign target = bus.branch_target & ~LOW_MASK;
`ifdef PC_ALIGN_CHECK_EN
  logic target_bad;
  assign target_bad = |(bus.branch_target & LOW_MASK);
  assign ret_addr   = ras_top;
`else
  assign ret_addr   = ras_top & ~LOW_MASK;
`endif

  pc_ras #(
    .WIDTH    (WIDTH),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .push_data(pc_inc),
    .top      (ras_top),
    .empty    (ras_empty),
    .full     (ras_full),
    .overflow (ras_overflow)
  );

  // Priority decode: trap > ret > call > branch > increment.
  // A ret on an empty stack falls through to increment and flags underflow.
  always_comb begin
    sel            = PC_SEL_INC;
    push           = 1'b0;
    pop            = 1'b0;
    underflow_next = 1'b0;
    misalign_next  = 1'b0;
    if (bus.trap) begin
      sel = PC_SEL_TRAP;
    end else if (bus.enable) begin
      if (bus.ret) begin
        if (ras_empty) begin
          underflow_next = 1'b1;
        end else begin
          sel = PC_SEL_RET;
          pop = 1'b1;
        end
      end else if (bus.call || bus.branch_taken) begin
`ifdef PC_ALIGN_CHECK_EN
        if (target_bad) begin
          sel           = PC_SEL_TRAP;
          misalign_next = 1'b1;
        end else begin
          sel  = PC_SEL_BR;
          push = bus.call;
        end
`else
        sel  = PC_SEL_BR;
        push = bus.call;
`endif
      end
    end
  end

  // Next-PC multiplexer.
  always_comb begin
    pc_next = pc_inc;
    unique case (sel)
      PC_SEL_INC:  pc_next = pc_inc;
      PC_SEL_BR:   pc_next = target;
      PC_SEL_RET:  pc_next = ret_addr;
      PC_SEL_TRAP: pc_next = TRAP_VEC;
      default:     pc_next = pc_inc;
    endcase
  end

  // PC register and one-cycle status pulses; stall holds pc unless trapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q        <= RESET_VEC;
      underflow_q <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      if (bus.trap || bus.enable) pc_q <= pc_next;
      underflow_q <= underflow_next;
      misalign_q  <= misalign_next;
    end
  end

  assign bus.pc            = pc_q;
  assign bus.ras_empty     = ras_empty;
  assign bus.ras_full      = ras_full;
  assign bus.ras_overflow  = ras_overflow;
  assign bus.ras_underflow = underflow_q;
`ifdef PC_ALIGN_CHECK_EN
  assign bus.misalign      = misalign_q;
`else
  logic unused_misalign;
  assign unused_misalign = misalign_q;
`endif

endmodule
